// File: rtl/led_blink_sched.sv
// Round-robin scheduler sharing one blink prescaler/LED among NREQ requesters.
// The winner owns the LED for HOLD full periods at its latched rate, then re-arbitrates.
module led_blink_sched #(
  parameter int NREQ  = 4,
  parameter int CBITS = 8,
  parameter int HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] sel,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              led,
  output logic              flg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(HOLD + 1);
  localparam int HW = CBITS + 1;

  typedef enum logic {IDLE, BLINK} state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               led_q, led_d;
  logic               flg_q, flg_d;
  logic [CBITS-1:0]   cnt_q, cnt_d;
  logic [CBITS-1:0]   hm1_q, hm1_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      own_q, own_d;

  logic               win_vld;
  logic [IW-1:0]      win_idx;
  logic [1:0]         sel_w;
  int                 idx_c;

  // Terminal count of the half period: 2**(CBITS-3+s) - 1, kept CBITS wide so
  // the slowest rate terminates on all-ones and wraps naturally.
  function automatic logic [CBITS-1:0] half_m1(input logic [1:0] s);
    logic [HW-1:0] h;
    h = HW'(1) << (CBITS - 3 + int'(s));
    return CBITS'(h - HW'(1));
  endfunction

  // Walk from the highest offset down so the offset closest to ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx_c   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_c = (int'(ptr_q) + k) % NREQ;
      if (req[idx_c]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx_c);
      end
    end
    sel_w = sel[2*int'(win_idx) +: 2];
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    led_d   = led_q;
    flg_d   = 1'b0;
    cnt_d   = cnt_q;
    hm1_d   = hm1_q;
    pcnt_d  = pcnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        led_d  = 1'b0;
        if (win_vld) begin
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          led_d   = 1'b1;
          cnt_d   = '0;
          pcnt_d  = '0;
          hm1_d   = half_m1(sel_w);
          ptr_d   = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
          own_d   = win_idx;
          state_d = BLINK;
        end
      end
      BLINK: begin
        if (!req[own_q]) begin
          // Owner withdrew: abort immediately, overriding any toggle this cycle.
          gnt_d   = '0;
          busy_d  = 1'b0;
          led_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != hm1_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = '0;
          if (led_q) begin
            led_d = 1'b0;
            flg_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
            if (int'(pcnt_q) + 1 < HOLD) begin
              led_d = 1'b1;
              flg_d = 1'b1;
            end else begin
              gnt_d   = '0;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      led_q   <= 1'b0;
      flg_q   <= 1'b0;
      cnt_q   <= '0;
      hm1_q   <= '0;
      pcnt_q  <= '0;
      ptr_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
      hm1_q   <= hm1_d;
      pcnt_q  <= pcnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign led  = led_q;
  assign flg  = flg_q;

endmodule
